// File: rtl/pc_sequencer_pkg.sv
// Shared types for the next-PC sequencer: FSM states, next-PC select codes, flush counter width.
// The PC_IRQ_EN build also uses the SEL_IRQ and SEL_ERET codes.
package pc_sequencer_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_JR,
    SEL_TMO,
    SEL_IRQ,
    SEL_ERET
  } sel_t;

  // Holds FLUSH_CYCLES-1 for FLUSH_CYCLES up to 7.
  localparam int FLUSH_CNT_W = 3;

  // Every select except hold and plain sequential fetch kills the younger stages.
  function automatic logic is_redirect(input sel_t s);
    return !(s inside {SEL_HOLD, SEL_SEQ});
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bundle between the execute-stage resolution logic, the PC register and pc_sequencer.
// irq and eret exist only when PC_IRQ_EN is defined.
interface pc_sequencer_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_q;
  logic            stall_hz;
  logic            md_start;
  logic            md_ready;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp;
  logic [PC_W-1:0] jmp_target;
  logic            jr;
  logic [PC_W-1:0] jr_target;
`ifdef PC_IRQ_EN
  logic            irq;
  logic            eret;
`endif
  logic [PC_W-1:0] pc_d;
  logic            pc_en;
  logic            flush;
  logic            md_busy;
  logic            md_err;

  modport master (
    input  pc_q, stall_hz, md_start, md_ready, br_taken, br_target,
           jmp, jmp_target, jr, jr_target,
`ifdef PC_IRQ_EN
    input  irq, eret,
`endif
    output pc_d, pc_en, flush, md_busy, md_err
  );

  modport slave (
    output pc_q, stall_hz, md_start, md_ready, br_taken, br_target,
           jmp, jmp_target, jr, jr_target,
`ifdef PC_IRQ_EN
    output irq, eret,
`endif
    input  pc_d, pc_en, flush, md_busy, md_err
  );

endinterface

// File: rtl/pc_sequencer_md_watchdog.sv
// Mult/div wait watchdog: counts enabled cycles since the last clear.
// tc fires on the MD_TIMEOUT-th enabled cycle.
module md_watchdog #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(MD_TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // count still holds the cycles already waited, so the current cycle is the MD_TIMEOUT-th one.
  assign tc = en && (count == CW'(MD_TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential/branch/jump/jr select, hazard and mult/div freeze, redirect flush.
// Optional interrupt entry/return (irq, eret, IRQ_VECTOR, epc) is built when PC_IRQ_EN is defined.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64
`ifdef PC_IRQ_EN
  , parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(32'h0000_0F00)
`endif
) (
  input  logic           clk,
  input  logic           clr,
  pc_sequencer_if.master bus
);

  state_t                 state_q, state_d;
  sel_t                   sel;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic                   md_err_q;
  logic                   wd_clear, wd_en, wd_tc;
  logic                   irq_take, eret_take;
  logic [PC_W-1:0]        pc_inc, pc_next;

`ifdef PC_IRQ_EN
  logic [PC_W-1:0] epc;
  logic            in_isr;

  assign irq_take  = bus.irq && !in_isr;
  assign eret_take = bus.eret;
`else
  assign irq_take  = 1'b0;
  assign eret_take = 1'b0;
`endif

  assign pc_inc = bus.pc_q + PC_W'(1);
  assign wd_en  = (state_q == MD_WAIT);

  md_watchdog #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_watchdog (
    .clk  (clk),
    .clr  (clr),
    .clear(wd_clear),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sel      = SEL_HOLD;
    state_d  = state_q;
    wd_clear = 1'b0;
    unique case (state_q)
      RUN: begin
        if (irq_take)          sel = SEL_IRQ;
        else if (eret_take)    sel = SEL_ERET;
        else if (bus.jr)       sel = SEL_JR;
        else if (bus.jmp)      sel = SEL_JMP;
        else if (bus.br_taken) sel = SEL_BR;
        else if (bus.md_start) begin
          state_d  = MD_WAIT;
          wd_clear = 1'b1;
        end else if (!bus.stall_hz) begin
          sel = SEL_SEQ;
        end
      end
      MD_WAIT: begin
        // A result arriving on the watchdog's last cycle wins over the abort.
        if (bus.md_ready) begin
          sel     = SEL_SEQ;
          state_d = RUN;
        end else if (wd_tc) begin
          sel     = SEL_TMO;
          state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SEL_HOLD: pc_next = bus.pc_q;
      SEL_BR:   pc_next = bus.br_target;
      SEL_JMP:  pc_next = bus.jmp_target;
      SEL_JR:   pc_next = bus.jr_target;
`ifdef PC_IRQ_EN
      SEL_IRQ:  pc_next = IRQ_VECTOR;
      SEL_ERET: pc_next = epc;
`endif
      default:  pc_next = pc_inc;
    endcase
  end

  // Outputs are combinational, so clr must mask them directly to look reset immediately.
  assign bus.pc_d    = clr ? '0 : pc_next;
  assign bus.pc_en   = !clr && (sel != SEL_HOLD);
  assign bus.flush   = !clr && (is_redirect(sel) || (flush_cnt_q != '0));
  assign bus.md_busy = (state_q == MD_WAIT);
  assign bus.md_err  = md_err_q || (sel == SEL_TMO);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      md_err_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      // A watchdog abort is treated like any redirect and gets the full flush window.
      if (is_redirect(sel)) begin
        flush_cnt_q <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      end else if (flush_cnt_q != '0) begin
        flush_cnt_q <= flush_cnt_q - 1'b1;
      end
      if (sel == SEL_TMO) begin
        md_err_q <= 1'b1;
      end
    end
  end

`ifdef PC_IRQ_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      epc    <= '0;
      in_isr <= 1'b0;
    end else if (sel == SEL_IRQ) begin
      epc    <= bus.pc_q;
      in_isr <= 1'b1;
    end else if (sel == SEL_ERET) begin
      in_isr <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed literal checks plus randomized traffic against a cycle model.
// Targets the default build; under PC_IRQ_EN the interrupt inputs are held low.
module tb_pc_sequencer;

  localparam int PC_W         = 32;
  localparam int FLUSH_CYCLES = 3;
  localparam int MD_TIMEOUT   = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(
    .PC_W        (PC_W),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .MD_TIMEOUT  (MD_TIMEOUT)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare process (negedge) ----------------
  bit              m_wait;
  int              m_wait_n;
  int              m_flush_left;
  bit              m_err;
  logic [PC_W-1:0] e_pc;
  bit              e_en, e_pc_chk, e_redir, e_tmo, e_to_wait, e_to_run;
  int              e_n;

  initial begin
    m_wait = 0; m_wait_n = 0; m_flush_left = 0; m_err = 0;
    forever begin
      @(negedge clk);
      if (clr) begin
        check("rst_pc_en",   bus.pc_en,   0);
        check("rst_pc_d",    bus.pc_d,    0);
        check("rst_flush",   bus.flush,   0);
        check("rst_md_busy", bus.md_busy, 0);
        check("rst_md_err",  bus.md_err,  0);
        m_wait = 0; m_wait_n = 0; m_flush_left = 0; m_err = 0;
      end else begin
        e_pc = bus.pc_q; e_en = 0; e_pc_chk = 0; e_redir = 0; e_tmo = 0;
        e_to_wait = 0; e_to_run = 0; e_n = m_wait_n + 1;
        if (!m_wait) begin
          if (bus.jr)            begin e_pc = bus.jr_target;  e_en = 1; e_redir = 1; end
          else if (bus.jmp)      begin e_pc = bus.jmp_target; e_en = 1; e_redir = 1; end
          else if (bus.br_taken) begin e_pc = bus.br_target;  e_en = 1; e_redir = 1; end
          else if (bus.md_start) e_to_wait = 1;
          else if (bus.stall_hz) e_pc_chk = 1;
          else begin e_pc = bus.pc_q + 1; e_en = 1; end
        end else begin
          if (bus.md_ready) begin
            e_pc = bus.pc_q + 1; e_en = 1; e_to_run = 1;
          end else if (e_n == MD_TIMEOUT) begin
            e_pc = bus.pc_q + 1; e_en = 1; e_redir = 1; e_tmo = 1; e_to_run = 1;
          end
        end
        check("pc_en", bus.pc_en, e_en);
        if (e_en || e_pc_chk) check("pc_d", bus.pc_d, e_pc);
        check("flush",   bus.flush,   e_redir || (m_flush_left > 0));
        check("md_busy", bus.md_busy, m_wait);
        check("md_err",  bus.md_err,  m_err || e_tmo);
        if (e_redir) m_flush_left = FLUSH_CYCLES - 1;
        else if (m_flush_left > 0) m_flush_left--;
        if (e_tmo) m_err = 1;
        if (e_to_wait) begin m_wait = 1; m_wait_n = 0; end
        else if (m_wait) begin
          if (e_to_run) m_wait = 0;
          else m_wait_n = e_n;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [PC_W-1:0] pc, input bit st, input bit ms, input bit mr,
                       input bit br, input logic [PC_W-1:0] bt, input bit j,
                       input logic [PC_W-1:0] jt, input bit r, input logic [PC_W-1:0] rt);
    @(posedge clk);
    #2;
    bus.pc_q = pc; bus.stall_hz = st; bus.md_start = ms; bus.md_ready = mr;
    bus.br_taken = br; bus.br_target = bt; bus.jmp = j; bus.jmp_target = jt;
    bus.jr = r; bus.jr_target = rt;
    #1;
  endtask

  task automatic idle(input logic [PC_W-1:0] pc);
    drive(pc, 0, 0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr_md_err", bus.md_err, 0);
    check("clr_pc_en",  bus.pc_en,  0);
    @(posedge clk);
    #2 clr = 1'b0;
  endtask

  initial begin
`ifdef PC_IRQ_EN
    bus.irq = 1'b0; bus.eret = 1'b0;
`endif
    bus.pc_q = '0; bus.stall_hz = 0; bus.md_start = 0; bus.md_ready = 0;
    bus.br_taken = 0; bus.br_target = '0; bus.jmp = 0; bus.jmp_target = '0;
    bus.jr = 0; bus.jr_target = '0;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;

    // Sequential fetch
    idle(32'h10);
    check("seq_pc_d", bus.pc_d, 32'h11);
    check("seq_pc_en", bus.pc_en, 1);
    check("seq_flush", bus.flush, 0);

    // Priority jr > jmp > br, flush lasts FLUSH_CYCLES
    drive(32'h20, 0, 0, 0, 1, 32'h30, 1, 32'h40, 1, 32'h80);
    check("prio_pc_d", bus.pc_d, 32'h80);
    check("prio_flush0", bus.flush, 1);
    idle(32'h80);
    check("prio_flush1", bus.flush, 1);
    idle(32'h81);
    check("prio_flush2", bus.flush, 1);
    idle(32'h82);
    check("prio_flush3", bus.flush, 0);

    // Hazard alone holds; redirect beats hazard
    drive(32'h83, 1, 0, 0, 0, '0, 0, '0, 0, '0);
    check("hz_pc_en", bus.pc_en, 0);
    check("hz_pc_d", bus.pc_d, 32'h83);
    drive(32'h83, 1, 0, 0, 1, 32'h55, 0, '0, 0, '0);
    check("hzbr_pc_d", bus.pc_d, 32'h55);
    check("hzbr_pc_en", bus.pc_en, 1);
    repeat (3) idle(32'h55);

    // Mult/div with result 5 cycles after issue
    drive(32'h08, 0, 1, 0, 0, '0, 0, '0, 0, '0);
    check("md_issue_en", bus.pc_en, 0);
    for (int i = 0; i < 4; i++) begin
      idle(32'h08);
      check("md_wait_busy", bus.md_busy, 1);
      check("md_wait_en", bus.pc_en, 0);
    end
    drive(32'h08, 0, 0, 1, 0, '0, 0, '0, 0, '0);
    check("md_done_pc_d", bus.pc_d, 32'h09);
    check("md_done_en", bus.pc_en, 1);
    idle(32'h09);
    check("md_after_busy", bus.md_busy, 0);

    // md_ready together with md_start still enters the wait
    drive(32'h30, 0, 1, 1, 0, '0, 0, '0, 0, '0);
    check("md_same_en", bus.pc_en, 0);
    drive(32'h30, 0, 0, 1, 0, '0, 0, '0, 0, '0);
    check("md_same_exit_pc_d", bus.pc_d, 32'h31);

    // Watchdog abort on the 8th wait cycle
    drive(32'h40, 0, 1, 0, 0, '0, 0, '0, 0, '0);
    for (int i = 1; i < MD_TIMEOUT; i++) begin
      idle(32'h40);
      check("wd_early_err", bus.md_err, 0);
    end
    idle(32'h40);
    check("wd_err", bus.md_err, 1);
    check("wd_flush", bus.flush, 1);
    check("wd_pc_en", bus.pc_en, 1);
    check("wd_pc_d", bus.pc_d, 32'h41);
    idle(32'h41);
    check("wd_sticky", bus.md_err, 1);
    check("wd_busy_off", bus.md_busy, 0);
    pulse_clr();

    // Wrap, then asynchronous clear in the middle of a wait
    idle(32'hFFFF_FFFF);
    check("wrap_pc_d", bus.pc_d, 0);
    drive(32'h50, 0, 1, 0, 0, '0, 0, '0, 0, '0);
    idle(32'h50);
    idle(32'h50);
    check("async_pre_busy", bus.md_busy, 1);
    clr = 1'b1;
    #1;
    check("async_busy", bus.md_busy, 0);
    check("async_pc_en", bus.pc_en, 0);
    @(posedge clk);
    #2 clr = 1'b0;

    // Randomized traffic checked by the model each cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      clr          = ($urandom_range(0, 249) == 0);
      bus.pc_q     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.stall_hz = ($urandom_range(0, 3) == 0);
      bus.md_start = ($urandom_range(0, 9) == 0);
      bus.md_ready = ($urandom_range(0, 5) == 0);
      bus.br_taken = ($urandom_range(0, 6) == 0);
      bus.jmp      = ($urandom_range(0, 9) == 0);
      bus.jr       = ($urandom_range(0, 9) == 0);
      bus.br_target  = $urandom;
      bus.jmp_target = $urandom;
      bus.jr_target  = $urandom;
    end
    @(posedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
